// File: rtl/hls_deadlock_report_ctrl.sv
// hls_deadlock_report_ctrl
//
// Purpose:
//   Qualifies the OR of the HLS deadlock monitors' `block` outputs over THRESH
//   consecutive cycles. When the threshold is reached it latches a sticky
//   deadlock flag, snapshots which monitors were blocking, and presents the
//   event once over a valid/ready handshake to the status collector.
//
// Ports:
//   clock          in   single clock for all logic
//   reset          in   synchronous, active-high reset
//   mon_block      in   [NUM_MON] block output of each monitor (bit i = monitor i)
//   clear          in   one-cycle pulse: drop sticky state, restart qualification
//   deadlock       out  sticky deadlock flag
//   deadlock_mask  out  [NUM_MON] mon_block snapshot at detection
//   first_idx      out  [IDX_W] lowest set index of deadlock_mask
//   block_cycles   out  [CNT_W] consecutive blocked-cycle count, saturating
//   report_valid   out  deadlock report pending
//   report_ready   in   collector accepts report
//   timestamp      out  [32] cycle stamp of detection
//
// Optional feature:
//   DEADLOCK_TIMESTAMP_EN - when defined, a free-running 32-bit cycle counter
//   is kept and its value on the detection edge is latched into timestamp.
//   When undefined, no counter exists and timestamp is tied to 0.

module hls_deadlock_report_ctrl #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned THRESH  = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               deadlock,
  output logic [NUM_MON-1:0] deadlock_mask,
  output logic [IDX_W-1:0]   first_idx,
  output logic [CNT_W-1:0]   block_cycles,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [31:0]        timestamp
);

  typedef enum logic [1:0] {StIdle, StCount, StReport, StDone} state_e;

  // Count value held just before the THRESH-th consecutive blocked sample.
  localparam logic [CNT_W-1:0] ThreshM1 = CNT_W'(THRESH - 1);

  state_e             state_q, state_d;
  logic               deadlock_q, deadlock_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               valid_q, valid_d;

  logic any_blk;
  logic detect;
  logic handshake;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
    lowest_idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign any_blk   = |mon_block;
  assign detect    = (state_q == StCount) && any_blk && (cycles_q == ThreshM1) && !clear;
  assign handshake = (state_q == StReport) && valid_q && report_ready && !clear;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides detection and handshake
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_blk) state_d = StCount;
        end
        StCount: begin
          if (!any_blk) begin
            state_d = StIdle;
          end else if (cycles_q == ThreshM1) begin
            state_d = StReport;
          end
        end
        StReport: begin
          if (valid_q && report_ready) state_d = StDone;
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    deadlock_d = deadlock_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    valid_d    = valid_q;

    // The counter runs in every state; it only tracks the current blocked run.
    if (clear || !any_blk) begin
      cycles_d = '0;
    end else if (cycles_q == {CNT_W{1'b1}}) begin
      cycles_d = cycles_q;
    end else begin
      cycles_d = cycles_q + CNT_W'(1);
    end

    if (clear) begin
      deadlock_d = 1'b0;
      mask_d     = '0;
      idx_d      = '0;
      valid_d    = 1'b0;
    end else if (detect) begin
      deadlock_d = 1'b1;
      mask_d     = mon_block;
      idx_d      = lowest_idx(mon_block);
      valid_d    = 1'b1;
    end else if (handshake) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock_q <= 1'b0;
      mask_q     <= '0;
      idx_q      <= '0;
      cycles_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      deadlock_q <= deadlock_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      cycles_q   <= cycles_d;
      valid_q    <= valid_d;
    end
  end

  assign deadlock      = deadlock_q;
  assign deadlock_mask = mask_q;
  assign first_idx     = idx_q;
  assign block_cycles  = cycles_q;
  assign report_valid  = valid_q;

`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ts_q, ts_d;

  // Stamp carries the counter value taken on the detection edge itself.
  assign cyc_d = cyc_q + 32'd1;

  always_comb begin
    ts_d = ts_q;
    if (clear) begin
      ts_d = '0;
    end else if (detect) begin
      ts_d = cyc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign timestamp = ts_q;
`else
  assign timestamp = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
module tb_hls_deadlock_report_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mon_block;
  logic        clear;
  logic        report_ready;
  logic        deadlock;
  logic [3:0]  deadlock_mask;
  logic [1:0]  first_idx;
  logic [3:0]  block_cycles;
  logic        report_valid;
  logic [31:0] timestamp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  hls_deadlock_report_ctrl #(
    .NUM_MON(4),
    .IDX_W  (2),
    .THRESH (8),
    .CNT_W  (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mon_block    (mon_block),
    .clear        (clear),
    .deadlock     (deadlock),
    .deadlock_mask(deadlock_mask),
    .first_idx    (first_idx),
    .block_cycles (block_cycles),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .timestamp    (timestamp)
  );

  typedef struct {
    logic       rst;
    logic [3:0] blk;
    logic       clr;
    logic       rdy;
    logic       e_dl;
    logic [3:0] e_mask;
    logic [1:0] e_idx;
    logic [3:0] e_cyc;
    logic       e_vld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] blk, input logic clr,
                              input logic rdy, input logic dl, input logic [3:0] mask,
                              input logic [1:0] idx, input logic [3:0] cyc, input logic vld);
    vec_t v;
    v.rst = rst; v.blk = blk; v.clr = clr; v.rdy = rdy;
    v.e_dl = dl; v.e_mask = mask; v.e_idx = idx; v.e_cyc = cyc; v.e_vld = vld;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] b, input logic c, input logic y);
    reset = r; mon_block = b; clear = c; report_ready = y;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; mon_block = '0; clear = 1'b0; report_ready = 1'b0;

`ifdef DEADLOCK_TIMESTAMP_EN
    // Timestamp: reset, idle on edges 1-2, block from edge 3 -> detect on edge 10.
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("ts_reset", 0, timestamp, 32'd0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int e = 3; e <= 9; e++) drive(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("ts_before_detect", 9, timestamp, 32'd0);
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("ts_detect_flag", 10, {31'd0, deadlock}, 32'd1);
    chk("ts_value", 10, timestamp, 32'd10);
    drive(1'b0, 4'b0001, 1'b0, 1'b1);
    chk("ts_hold", 11, timestamp, 32'd10);
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    chk("ts_clear", 12, timestamp, 32'd0);
`endif

    // A: reset while blocked, then single monitor held to detection, then accept.
    add(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 1; c <= 7; c++) add(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b0100, 0, 0, 1, 4'b0100, 2, 8, 1);
    add(0, 4'b0100, 0, 1, 1, 4'b0100, 2, 9, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0);
    // B: one-cycle gap discards a partial count.
    for (int c = 1; c <= 7; c++) add(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 1; c <= 7; c++) add(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b0001, 0, 0, 1, 4'b0001, 0, 8, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0);
    // C: backpressure holds valid and mask; counter saturates at 15 in DONE.
    for (int c = 1; c <= 7; c++) add(0, 4'b1010, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b1010, 0, 0, 1, 4'b1010, 1, 8, 1);
    for (int c = 9; c <= 11; c++) add(0, 4'b1010, 0, 0, 1, 4'b1010, 1, 4'(c), 1);
    for (int c = 12; c <= 13; c++) add(0, 4'b0001, 0, 0, 1, 4'b1010, 1, 4'(c), 1);
    add(0, 4'b0010, 0, 1, 1, 4'b1010, 1, 14, 0);
    add(0, 4'b0010, 0, 0, 1, 4'b1010, 1, 15, 0);
    add(0, 4'b0010, 0, 1, 1, 4'b1010, 1, 15, 0);
    // D: clear in DONE while still blocked, recount and re-detect.
    add(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 1; c <= 7; c++) add(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b0010, 0, 0, 1, 4'b0010, 1, 8, 1);
    // E: reset mid-count; then clear+ready on the detection edge.
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 1; c <= 5; c++) add(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 0, 0);
    for (int c = 1; c <= 7; c++) add(0, 4'b1000, 0, 0, 0, 4'b0000, 0, 4'(c), 0);
    add(0, 4'b1000, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 0, 0, 0, 4'b0000, 0, 1, 0);
    // F: changing monitors keep the run alive; multi-bit mask gives lowest index.
    add(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 2, 0);
    add(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 3, 0);
    add(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 4, 0);
    add(0, 4'b1000, 0, 0, 0, 4'b0000, 0, 5, 0);
    add(0, 4'b0011, 0, 0, 0, 4'b0000, 0, 6, 0);
    add(0, 4'b1001, 0, 0, 0, 4'b0000, 0, 7, 0);
    add(0, 4'b0110, 0, 0, 1, 4'b0110, 1, 8, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].blk, vecs[i].clr, vecs[i].rdy);
      chk("deadlock", i, {31'd0, deadlock}, {31'd0, vecs[i].e_dl});
      chk("deadlock_mask", i, {28'd0, deadlock_mask}, {28'd0, vecs[i].e_mask});
      chk("first_idx", i, {30'd0, first_idx}, {30'd0, vecs[i].e_idx});
      chk("block_cycles", i, {28'd0, block_cycles}, {28'd0, vecs[i].e_cyc});
      chk("report_valid", i, {31'd0, report_valid}, {31'd0, vecs[i].e_vld});
`ifndef DEADLOCK_TIMESTAMP_EN
      chk("timestamp_zero", i, timestamp, 32'd0);
`endif
    end

    // Long backpressure: valid must never drop without ready.
    for (int c = 1; c <= 8; c++) drive(1'b0, 4'b1000, 1'b0, 1'b0);
    chk("long_detect", 0, {31'd0, deadlock}, 32'd1);
    chk("long_idx", 0, {30'd0, first_idx}, 32'd3);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, (c % 2 == 0) ? 4'b0000 : 4'b0101, 1'b0, 1'b0);
      chk("long_valid_held", c, {31'd0, report_valid}, 32'd1);
      chk("long_mask_held", c, {28'd0, deadlock_mask}, 32'h8);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("long_accept_valid", 0, {31'd0, report_valid}, 32'd0);
    chk("long_accept_sticky", 0, {31'd0, deadlock}, 32'd1);
`ifndef DEADLOCK_TIMESTAMP_EN
    chk("long_timestamp_zero", 0, timestamp, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
